chacha20_core_arbiter: RTL
==========================

# chacha20_core_arbiter

Shares a single `chacha20_encrypt` core between two independent stream requesters, S0 and S1. It grants sessions round-robin and latches the winner's key, counter and nonce. It pulses `start` to the core, then steers the winner's 32-bit valid/ready streams through the core until the core signals `done`. It sits between the encrypt/decrypt clients and the shared core, so two channels run ChaCha20 sessions without duplicating the cipher datapath.

## Interface
- `CNT_W`, default 16: width of the per-session input-beat counter `session_words`; saturates at all-ones.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sN_req`  input  1  (N=0,1) session request; held high until `sN_gnt`.
- `sN_key`  input  256  session key; sampled in the grant cycle only.
- `sN_counter`  input  32  initial block counter; sampled in the grant cycle.
- `sN_nonce`  input  96  nonce; sampled in the grant cycle.
- `sN_in_data` / `sN_in_valid` / `sN_in_last`  input  32/1/1  requester input stream (plaintext or ciphertext).
- `sN_in_ready`  output  1  input stream ready.
- `sN_out_data` / `sN_out_valid` / `sN_out_last`  output  32/1/1  result stream.
- `sN_out_ready`  input  1  result stream ready.
- `sN_gnt`  output  1  registered; high from grant through the DONE state.
- `sN_done`  output  1  one-cycle pulse at session end.
- `core_start`  output  1  one-cycle start pulse to the core.
- `core_key` / `core_counter` / `core_nonce`  output  256/32/96  latched configuration; held stable for the whole session.
- `core_in_data` / `core_in_valid` / `core_in_last`  output  32/1/1  to core plaintext port.
- `core_in_ready`  input  1  from core.
- `core_out_data` / `core_out_valid` / `core_out_last`  input  32/1/1  from core ciphertext port.
- `core_out_ready`  output  1  to core.
- `core_done`  input  1  core session complete.
- `session_words`  output  CNT_W  input beats accepted in the current or last session.

## Operation
- FSM states: IDLE, LOAD, STREAM, DONE. Only reset moves the FSM outside these transitions.
- IDLE:
  - If any `sN_req` is high, pick the winner by round-robin. The winner is the requester other than `last_gnt` when both request; otherwise the sole requester.
  - On the pick: latch the winner's key, counter and nonce; set `sel`; clear `session_words`; go to LOAD.
- LOAD:
  - `core_start`=1 for exactly this cycle.
  - `sN_gnt` for `sel` is 1 from this state onward.
  - Always go to STREAM.
- STREAM, input path:
  - `core_in_*` = selected `sN_in_*`.
  - `sN_in_ready` = `core_in_ready` & `!in_closed`.
  - `core_in_valid` is gated by `!in_closed`.
  - `in_closed` sets after a beat with `last` is accepted.
- STREAM, output path:
  - `sN_out_*` = `core_out_*`.
  - `core_out_ready` = selected `sN_out_ready`.
- STREAM, counting and exit:
  - Each accepted input beat increments `session_words`, saturating.
  - `core_done`=1 → go to DONE.
- DONE:
  - `sN_done`=1 for `sel` for one cycle.
  - `last_gnt` ← `sel`.
  - Go to IDLE; `gnt` drops on that transition.
- Non-selected requester: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0 at all times.
- Outside STREAM: `core_in_valid`=0, `core_out_ready`=0, all `sN_in_ready`=0, all `sN_out_valid`=0.
- `core_done` outside STREAM is ignored.
- A request deasserted before its grant has no effect and leaves no pending state.
- `sN_req` seen during a session waits; it is evaluated only in IDLE.

## Timing
- Reset values:
  - state=IDLE, `last_gnt`=1, so S0 wins the first contention.
  - `gnt`=0, `done`=0, `core_start`=0, `session_words`=0.
  - `core_key`/`core_counter`/`core_nonce`=0, `in_closed`=0.
  - All combinational stream outputs are 0 as a result.
- Reset asserted mid-session aborts immediately. The core shares `rst_n`, so both return to idle together.
- Request at cycle t in IDLE:
  - t+1: LOAD, `gnt`=1, `core_start`=1.
  - t+2: first cycle data can pass (STREAM).
- Stream handshakes are combinational pass-through, with zero added latency.
- `core_done` at cycle k:
  - k+1: DONE, `sN_done`=1.
  - k+2: IDLE, `gnt`=0.
  - Earliest next LOAD: k+3.

## Test plan
- Reset, single requester: S0 requests with key 0x00..1f, counter 1, nonce 0x000000000000004a00000000.
  - Required: `core_start` exactly one cycle at t+1.
  - Required: `core_key`/`core_counter`/`core_nonce` equal S0's values and stay stable.
  - Required: 16 input beats pass through; `session_words`=16; `s0_done` one pulse; S1 streams idle throughout.
- Simultaneous S0+S1 requests over 3 sessions, S1 re-requesting each time. Required grant order: S0, S1, S0.
- Backpressure: `s1_out_ready` toggles 1-0-0-1.
  - Required: `core_out_ready` mirrors it cycle-for-cycle.
  - Required: no beat is lost or duplicated; the core stub's output sequence matches the bench's captured output.
- Input after last: a beat with `last` at beat 3, then `s0_in_valid` is held high.
  - Required: `s0_in_ready`=0 and `core_in_valid`=0 until DONE.
  - Required: `session_words`=3.
- Spurious `core_done` in IDLE and LOAD: no state change, no `sN_done`.
- Counter saturation and reset abort, with `CNT_W`=2:
  - Feed 5 beats: `session_words`=3.
  - Drop `rst_n` mid-STREAM: all outputs 0 asynchronously.
  - Next contention after reset is granted to S0.

Source files
------------

// File: rtl/chacha20_core_arbiter.sv
// chacha20_core_arbiter: round-robin sharing of one chacha20_encrypt core between two stream requesters
module chacha20_core_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_req,
  input  logic [255:0]     s0_key,
  input  logic [31:0]      s0_counter,
  input  logic [95:0]      s0_nonce,
  input  logic [31:0]      s0_in_data,
  input  logic             s0_in_valid,
  input  logic             s0_in_last,
  output logic             s0_in_ready,
  output logic [31:0]      s0_out_data,
  output logic             s0_out_valid,
  output logic             s0_out_last,
  input  logic             s0_out_ready,
  output logic             s0_gnt,
  output logic             s0_done,
  input  logic             s1_req,
  input  logic [255:0]     s1_key,
  input  logic [31:0]      s1_counter,
  input  logic [95:0]      s1_nonce,
  input  logic [31:0]      s1_in_data,
  input  logic             s1_in_valid,
  input  logic             s1_in_last,
  output logic             s1_in_ready,
  output logic [31:0]      s1_out_data,
  output logic             s1_out_valid,
  output logic             s1_out_last,
  input  logic             s1_out_ready,
  output logic             s1_gnt,
  output logic             s1_done,
  output logic             core_start,
  output logic [255:0]     core_key,
  output logic [31:0]      core_counter,
  output logic [95:0]      core_nonce,
  output logic [31:0]      core_in_data,
  output logic             core_in_valid,
  output logic             core_in_last,
  input  logic             core_in_ready,
  input  logic [31:0]      core_out_data,
  input  logic             core_out_valid,
  input  logic             core_out_last,
  output logic             core_out_ready,
  input  logic             core_done,
  output logic [CNT_W-1:0] session_words
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
  state_t state;
  logic sel, last_gnt, in_closed;
  logic stream, pick, s0_on, s1_on, sel_in_valid, sel_in_last, accept;
  logic [31:0] sel_in_data;
  assign stream = state == STREAM;
  assign s0_on = stream && !sel;
  assign s1_on = stream && sel;
  // both requesting: the one not served last wins
  assign pick = (s0_req && s1_req) ? !last_gnt : s1_req;
  assign sel_in_valid = sel ? s1_in_valid : s0_in_valid;
  assign sel_in_last = sel ? s1_in_last : s0_in_last;
  assign sel_in_data = sel ? s1_in_data : s0_in_data;
  assign core_in_valid = stream && !in_closed && sel_in_valid;
  assign core_in_last = stream && sel_in_last;
  assign core_in_data = stream ? sel_in_data : '0;
  assign core_out_ready = stream && (sel ? s1_out_ready : s0_out_ready);
  assign accept = core_in_valid && core_in_ready;
  assign s0_in_ready = s0_on && !in_closed && core_in_ready;
  assign s1_in_ready = s1_on && !in_closed && core_in_ready;
  assign s0_out_valid = s0_on && core_out_valid;
  assign s1_out_valid = s1_on && core_out_valid;
  assign s0_out_last = s0_on && core_out_last;
  assign s1_out_last = s1_on && core_out_last;
  assign s0_out_data = s0_on ? core_out_data : '0;
  assign s1_out_data = s1_on ? core_out_data : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= 1'b0;
      last_gnt <= 1'b1;
      in_closed <= 1'b0;
      s0_gnt <= 1'b0;
      s1_gnt <= 1'b0;
      s0_done <= 1'b0;
      s1_done <= 1'b0;
      core_start <= 1'b0;
      core_key <= '0;
      core_counter <= '0;
      core_nonce <= '0;
      session_words <= '0;
    end else begin
      core_start <= 1'b0;
      s0_done <= 1'b0;
      s1_done <= 1'b0;
      case (state)
        IDLE: if (s0_req || s1_req) begin
          state <= LOAD;
          sel <= pick;
          s0_gnt <= !pick;
          s1_gnt <= pick;
          core_start <= 1'b1;
          core_key <= pick ? s1_key : s0_key;
          core_counter <= pick ? s1_counter : s0_counter;
          core_nonce <= pick ? s1_nonce : s0_nonce;
          session_words <= '0;
          in_closed <= 1'b0;
        end
        LOAD: state <= STREAM;
        STREAM: begin
          if (accept && session_words != '1) session_words <= session_words + CNT_W'(1);
          if (accept && sel_in_last) in_closed <= 1'b1;
          if (core_done) begin
            state <= DONE;
            s0_done <= !sel;
            s1_done <= sel;
          end
        end
        DONE: begin
          state <= IDLE;
          last_gnt <= sel;
          s0_gnt <= 1'b0;
          s1_gnt <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
